// File: rtl/reaction_session_ctrl_if.sv
// Handshake and result bundle between the reaction-session sequencer and its
// neighbours: button synchronizers, delay timer, ms tick and the score path.
interface reaction_session_ctrl_if;
  logic        Start;
  logic        Stop;
  logic        MSen;
  logic        CNTdone;
  logic        CNTstart;
  logic        LED;
  logic        SCupdate;
  logic [13:0] RoundTime;
  logic [13:0] BestTime;
  logic [13:0] Average;
  logic [3:0]  RoundIdx;
  logic        FalseStart;
  logic        SessionDone;

  modport master (
    output Start, Stop, MSen, CNTdone,
    input  CNTstart, LED, SCupdate, RoundTime, BestTime, Average,
    input  RoundIdx, FalseStart, SessionDone
  );

  modport slave (
    input  Start, Stop, MSen, CNTdone,
    output CNTstart, LED, SCupdate, RoundTime, BestTime, Average,
    output RoundIdx, FalseStart, SessionDone
  );
endinterface

// File: rtl/reaction_session_ctrl.sv
// Reaction-timer session sequencer: runs NUM_ROUNDS rounds of delay/react/record
// and keeps per-round, best and average reaction times with false-start tracking.
module reaction_session_ctrl #(
  parameter int NUM_ROUNDS = 4,
  parameter int TIMEOUT_MS = 9999,
  parameter int PENALTY_MS = 1000
) (
  input logic              Clk,
  input logic              Reset,
  reaction_session_ctrl_if.slave bus
);
  localparam int LOG2_ROUNDS = $clog2(NUM_ROUNDS);
  localparam int TOTAL_W     = 14 + LOG2_ROUNDS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DELAY  = 3'd1;
  localparam logic [2:0] S_REACT  = 3'd2;
  localparam logic [2:0] S_RECORD = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [13:0] BEST_INIT = 14'h3FFF;
  localparam logic [13:0] TIMEOUT_V = 14'(TIMEOUT_MS);
  localparam logic [13:0] PENALTY_V = 14'(PENALTY_MS);
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_ROUNDS - 1);

  logic [2:0]         state_r, state_nxt_s;
  logic               start_d_r, stop_d_r;
  logic               start_edge_s, stop_edge_s;
  logic [13:0]        round_time_r, round_time_nxt_s;
  logic [13:0]        best_r, best_nxt_s;
  logic [TOTAL_W-1:0] total_r, total_nxt_s;
  logic [13:0]        avg_r, avg_nxt_s;
  logic [3:0]         idx_r, idx_nxt_s;
  logic               false_r, false_nxt_s;
  logic               cnt_start_r, cnt_start_nxt_s;
  logic               sc_update_r, sc_update_nxt_s;
  logic               led_r, done_r;

  function automatic logic [13:0] min_time(input logic [13:0] a, input logic [13:0] b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  assign start_edge_s = bus.Start & ~start_d_r;
  assign stop_edge_s  = bus.Stop & ~stop_d_r;

  // Next-state and datapath decisions for the round sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    round_time_nxt_s = round_time_r;
    best_nxt_s       = best_r;
    total_nxt_s      = total_r;
    idx_nxt_s        = idx_r;
    false_nxt_s      = false_r;
    cnt_start_nxt_s  = 1'b0;
    sc_update_nxt_s  = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_edge_s) begin
          total_nxt_s      = '0;
          idx_nxt_s        = 4'd0;
          round_time_nxt_s = 14'd0;
          false_nxt_s      = 1'b0;
          best_nxt_s       = BEST_INIT;
          cnt_start_nxt_s  = 1'b1;
          state_nxt_s      = S_DELAY;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_DELAY: begin
        // A Stop coinciding with expiry counts as a zero-time reaction.
        if (stop_edge_s) begin
          sc_update_nxt_s = 1'b1;
          state_nxt_s     = S_RECORD;
          if (bus.CNTdone) begin
            round_time_nxt_s = 14'd0;
          end else begin
            round_time_nxt_s = PENALTY_V;
            false_nxt_s      = 1'b1;
          end
        end else if (bus.CNTdone) begin
          round_time_nxt_s = 14'd0;
          state_nxt_s      = S_REACT;
        end else begin
          state_nxt_s = S_DELAY;
        end
      end
      S_REACT: begin
        if (stop_edge_s || (round_time_r == TIMEOUT_V)) begin
          sc_update_nxt_s = 1'b1;
          state_nxt_s     = S_RECORD;
        end else if (bus.MSen) begin
          round_time_nxt_s = round_time_r + 14'd1;
        end else begin
          round_time_nxt_s = round_time_r;
        end
      end
      S_RECORD: begin
        total_nxt_s = total_r + {{LOG2_ROUNDS{1'b0}}, round_time_r};
        best_nxt_s  = min_time(best_r, round_time_r);
        idx_nxt_s   = idx_r + 4'd1;
        if (idx_r == LAST_IDX) begin
          state_nxt_s = S_DONE;
        end else begin
          cnt_start_nxt_s = 1'b1;
          state_nxt_s     = S_DELAY;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
    avg_nxt_s = total_nxt_s[TOTAL_W-1 -: 14];
  end

  // State, statistics and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= S_IDLE;
      start_d_r    <= 1'b0;
      stop_d_r     <= 1'b0;
      round_time_r <= 14'd0;
      best_r       <= BEST_INIT;
      total_r      <= '0;
      avg_r        <= 14'd0;
      idx_r        <= 4'd0;
      false_r      <= 1'b0;
      cnt_start_r  <= 1'b0;
      sc_update_r  <= 1'b0;
      led_r        <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      start_d_r    <= bus.Start;
      stop_d_r     <= bus.Stop;
      round_time_r <= round_time_nxt_s;
      best_r       <= best_nxt_s;
      total_r      <= total_nxt_s;
      avg_r        <= avg_nxt_s;
      idx_r        <= idx_nxt_s;
      false_r      <= false_nxt_s;
      cnt_start_r  <= cnt_start_nxt_s;
      sc_update_r  <= sc_update_nxt_s;
      led_r        <= (state_nxt_s == S_REACT);
      done_r       <= (state_nxt_s == S_DONE);
    end
  end

  assign bus.CNTstart    = cnt_start_r;
  assign bus.LED         = led_r;
  assign bus.SCupdate    = sc_update_r;
  assign bus.RoundTime   = round_time_r;
  assign bus.BestTime    = best_r;
  assign bus.Average     = avg_r;
  assign bus.RoundIdx    = idx_r;
  assign bus.FalseStart  = false_r;
  assign bus.SessionDone = done_r;
endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Randomized scoreboard bench for reaction_session_ctrl: a driver plays whole
// sessions and a negedge monitor checks each recorded round and session result.
module tb_reaction_session_ctrl;
  localparam int NR  = 4;
  localparam int TO  = 9999;
  localparam int PEN = 1000;
  localparam int K_NORMAL  = 0;
  localparam int K_FALSE   = 1;
  localparam int K_SIMUL   = 2;
  localparam int K_TIMEOUT = 3;

  typedef struct { int rt; int led; int idx; } rnd_t;
  typedef struct { int avg; int best; int idx; int fs; } done_t;

  logic clk = 1'b0;
  logic reset;
  reaction_session_ctrl_if bus();

  reaction_session_ctrl #(.NUM_ROUNDS(NR), .TIMEOUT_MS(TO), .PENALTY_MS(PEN)) dut (
    .Clk(clk), .Reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  rnd_t  rnd_q[$];
  done_t done_q[$];
  int cnt_seen = 0;
  int cnt_consumed = 0;
  bit led_seen = 1'b0;
  bit done_prev = 1'b0;
  int s_kind[NR];
  int s_ticks[NR];
  int s_msat[NR];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference rule for the time a round records, from its kind and tick count.
  function automatic int exp_rt(input int kind, input int ticks);
    case (kind)
      K_FALSE:   return PEN;
      K_SIMUL:   return 0;
      K_TIMEOUT: return TO;
      default:   return (ticks > TO) ? TO : ticks;
    endcase
  endfunction

  // Monitor: counts CNTstart pulses, tracks LED per round, checks results.
  always @(negedge clk) begin
    rnd_t e;
    done_t d;
    if (bus.CNTstart) begin
      cnt_seen++;
      led_seen = 1'b0;
    end
    if (bus.LED) led_seen = 1'b1;
    if (bus.SCupdate) begin
      chk("sc_cnt_exclusive", bus.CNTstart, 0);
      if (rnd_q.size() == 0) begin
        chk("unexpected_scupdate", 1, 0);
      end else begin
        e = rnd_q.pop_front();
        chk("round_time", bus.RoundTime, e.rt);
        chk("round_led", led_seen, e.led);
        chk("round_idx", bus.RoundIdx, e.idx);
      end
    end
    if (bus.SessionDone && !done_prev) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        d = done_q.pop_front();
        chk("average", bus.Average, d.avg);
        chk("best_time", bus.BestTime, d.best);
        chk("done_idx", bus.RoundIdx, d.idx);
        chk("false_start", bus.FalseStart, d.fs);
      end
    end
    done_prev = bus.SessionDone;
  end

  task automatic wait_cnt_start();
    int n = 0;
    while (cnt_seen <= cnt_consumed && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cnt_start_wait", (cnt_seen > cnt_consumed) ? 1 : 0, 1);
    cnt_consumed++;
  endtask

  task automatic play_round(input int kind, input int ticks, input int ms_at_stop, input bit abort);
    int n;
    wait_cnt_start();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    case (kind)
      K_FALSE: begin
        bus.Stop = 1'b1; @(negedge clk); bus.Stop = 1'b0;
      end
      K_SIMUL: begin
        bus.Stop = 1'b1; bus.CNTdone = 1'b1; @(negedge clk);
        bus.Stop = 1'b0; bus.CNTdone = 1'b0;
      end
      default: begin
        bus.CNTdone = 1'b1; @(negedge clk); bus.CNTdone = 1'b0;
        if (kind == K_TIMEOUT) begin
          bus.MSen = 1'b1;
          n = 0;
          while (bus.LED && n < 10100) begin
            @(negedge clk);
            n++;
          end
          chk("timeout_led_drop", bus.LED, 0);
          repeat (3) @(negedge clk);
          bus.MSen = 1'b0;
          chk("timeout_saturated", bus.RoundTime, TO);
        end else begin
          for (int i = 0; i < ticks; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.MSen = 1'b1; @(negedge clk); bus.MSen = 1'b0;
          end
          if (abort) begin
            chk("led_before_reset", bus.LED, 1);
            reset = 1'b1; @(negedge clk); reset = 1'b0;
            chk("abort_led", bus.LED, 0);
            chk("abort_idx", bus.RoundIdx, 0);
            chk("abort_best", bus.BestTime, 16383);
            chk("abort_scupdate", bus.SCupdate, 0);
            chk("abort_done", bus.SessionDone, 0);
            cnt_consumed = cnt_seen;
          end else begin
            bus.Stop = 1'b1; bus.MSen = ms_at_stop[0]; @(negedge clk);
            bus.Stop = 1'b0; bus.MSen = 1'b0;
          end
        end
      end
    endcase
  endtask

  task automatic run_session(input bit hold, input int abort_round);
    int sum, best, fs, rt, n;
    rnd_t e;
    done_t d;
    sum = 0; best = 16383; fs = 0;
    for (int r = 0; r < NR; r++) begin
      rt = exp_rt(s_kind[r], s_ticks[r]);
      sum += rt;
      if (rt < best) best = rt;
      if (s_kind[r] == K_FALSE) fs = 1;
    end
    if (abort_round < 0) begin
      d.avg = sum / NR; d.best = best; d.idx = NR; d.fs = fs;
      done_q.push_back(d);
    end
    bus.Start = 1'b1; @(negedge clk);
    if (!hold) bus.Start = 1'b0;
    for (int r = 0; r < NR; r++) begin
      if (r == abort_round) begin
        play_round(s_kind[r], s_ticks[r], 0, 1'b1);
        return;
      end
      e.rt  = exp_rt(s_kind[r], s_ticks[r]);
      e.led = (s_kind[r] == K_NORMAL || s_kind[r] == K_TIMEOUT) ? 1 : 0;
      e.idx = r;
      rnd_q.push_back(e);
      play_round(s_kind[r], s_ticks[r], s_msat[r], 1'b0);
    end
    n = 0;
    while (done_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("session_done_seen", done_q.size(), 0);
  endtask

  task automatic set_round(input int r, input int kind, input int ticks, input int msat);
    s_kind[r] = kind; s_ticks[r] = ticks; s_msat[r] = msat;
  endtask

  task automatic random_session();
    for (int r = 0; r < NR; r++)
      set_round(r, $urandom_range(0, 2), $urandom_range(0, 400), $urandom_range(0, 1));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.Start = 1'b0; bus.Stop = 1'b0; bus.MSen = 1'b0; bus.CNTdone = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", bus.LED, 0);
    chk("rst_cntstart", bus.CNTstart, 0);
    chk("rst_scupdate", bus.SCupdate, 0);
    chk("rst_roundtime", bus.RoundTime, 0);
    chk("rst_best", bus.BestTime, 16383);
    chk("rst_average", bus.Average, 0);
    chk("rst_idx", bus.RoundIdx, 0);
    chk("rst_falsestart", bus.FalseStart, 0);
    chk("rst_done", bus.SessionDone, 0);
    reset = 1'b0;
    @(negedge clk);

    set_round(0, K_NORMAL, 200, 0); set_round(1, K_NORMAL, 300, 0);
    set_round(2, K_NORMAL, 250, 0); set_round(3, K_NORMAL, 251, 0);
    run_session(1'b0, -1);

    set_round(0, K_NORMAL, $urandom_range(0, 400), 0); set_round(1, K_FALSE, 0, 0);
    set_round(2, K_NORMAL, $urandom_range(0, 400), 1); set_round(3, K_NORMAL, $urandom_range(0, 400), 0);
    run_session(1'b0, -1);

    set_round(0, K_TIMEOUT, 0, 0); set_round(1, K_NORMAL, $urandom_range(0, 400), 0);
    set_round(2, K_NORMAL, $urandom_range(0, 400), 0); set_round(3, K_NORMAL, $urandom_range(0, 400), 1);
    run_session(1'b0, -1);

    set_round(0, K_SIMUL, 0, 0); set_round(1, K_NORMAL, 149, 1);
    set_round(2, K_NORMAL, $urandom_range(0, 400), 0); set_round(3, K_NORMAL, $urandom_range(0, 400), 0);
    run_session(1'b0, -1);

    set_round(0, K_NORMAL, $urandom_range(0, 400), 0); set_round(1, K_NORMAL, $urandom_range(0, 400), 0);
    set_round(2, K_NORMAL, 120, 0); set_round(3, K_NORMAL, 10, 0);
    run_session(1'b0, 2);
    chk("abort_queue_empty", rnd_q.size(), 0);
    @(negedge clk);

    set_round(0, K_NORMAL, $urandom_range(0, 400), 0); set_round(1, K_FALSE, 0, 0);
    set_round(2, K_NORMAL, $urandom_range(0, 400), 0); set_round(3, K_NORMAL, $urandom_range(0, 400), 0);
    run_session(1'b1, -1);
    bus.Start = 1'b0; @(negedge clk);
    bus.Start = 1'b1; @(negedge clk);
    chk("restart_cntstart", bus.CNTstart, 1);
    chk("restart_idx", bus.RoundIdx, 0);
    chk("restart_best", bus.BestTime, 16383);
    chk("restart_falsestart", bus.FalseStart, 0);
    chk("restart_done", bus.SessionDone, 0);
    chk("restart_roundtime", bus.RoundTime, 0);
    bus.Start = 1'b0;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    cnt_consumed = cnt_seen;
    @(negedge clk);

    for (int s = 0; s < 3; s++) begin
      random_session();
      run_session(1'b0, -1);
    end

    chk("final_round_queue", rnd_q.size(), 0);
    chk("final_done_queue", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
